// File: rtl/iir_m_feeder.sv
// iir_m_feeder: stream-side initiator for the multi-cycle IIR_m biquad.
// Input FIFO -> one sample at a time to the filter (f_din held for the whole
// filter sequence) -> result captured into the output FIFO -> m_* stream.
// A filter that never answers is aborted after TIMEOUT wait cycles and a zero
// is returned in its place so sample count and order are preserved.
// Optional: define IIR_FEEDER_STAT_EN to add stat_samples / stat_timeouts.
module iir_m_feeder #(
    parameter int DW        = 18,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [DW-1:0] f_din,
    output logic          f_din_valid,
    input  logic [DW-1:0] f_dout,
    input  logic          f_dout_valid,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          busy,
    output logic          timeout_err
`ifdef IIR_FEEDER_STAT_EN
    ,
    output logic [15:0]   stat_samples,
    output logic [7:0]    stat_timeouts
`endif
);
    localparam int IAW = $clog2(IN_DEPTH);
    localparam int ICW = $clog2(IN_DEPTH + 1);
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam int OCW = $clog2(OUT_DEPTH + 1);
    localparam int TCW = $clog2(TIMEOUT + 1);
    localparam logic [ICW-1:0] IN_FULL  = ICW'(IN_DEPTH);
    localparam logic [OCW-1:0] OUT_FULL = OCW'(OUT_DEPTH);
    localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t         state_q, state_d;
    logic [TCW-1:0] tmo_q, tmo_d;
    logic [DW-1:0]  f_din_q;
    logic           tmo_err_q;

    logic [DW-1:0]  in_mem_q [IN_DEPTH];
    logic [IAW-1:0] in_wr_q, in_rd_q;
    logic [ICW-1:0] in_cnt_q, in_cnt_d;
    logic [DW-1:0]  out_mem_q [OUT_DEPTH];
    logic [OAW-1:0] out_wr_q, out_rd_q;
    logic [OCW-1:0] out_cnt_q, out_cnt_d;

    logic           in_push, in_pop, out_wr, out_pop, tmo_hit, done, issue_go;
    logic [DW-1:0]  out_wdata;

    // FIFO handshakes and WAIT completion (result or timeout)
    always_comb begin
        s_ready   = rst && (in_cnt_q != IN_FULL);
        in_push   = s_valid && s_ready;
        in_pop    = (state_q == ISSUE);
        m_valid   = (out_cnt_q != '0);
        out_pop   = m_valid && m_ready;
        tmo_hit   = (state_q == WAIT) && !f_dout_valid && (tmo_q == TMO_LAST);
        done      = (state_q == WAIT) && (f_dout_valid || tmo_hit);
        out_wr    = done;
        out_wdata = f_dout_valid ? f_dout : '0;
        issue_go  = (state_d == ISSUE);
    end

    // occupancy next-state; simultaneous push/pop leaves the count unchanged
    always_comb begin
        in_cnt_d = in_cnt_q;
        if (in_push && !in_pop)      in_cnt_d = in_cnt_q + ICW'(1);
        else if (!in_push && in_pop) in_cnt_d = in_cnt_q - ICW'(1);
        out_cnt_d = out_cnt_q;
        if (out_wr && !out_pop)      out_cnt_d = out_cnt_q + OCW'(1);
        else if (!out_wr && out_pop) out_cnt_d = out_cnt_q - OCW'(1);
    end

    // FSM next state; a finishing WAIT may issue directly so back-to-back
    // samples are spaced 7 cycles apart
    always_comb begin
        state_d = state_q;
        tmo_d   = '0;
        unique case (state_q)
            IDLE:  if (in_cnt_q != '0 && out_cnt_q != OUT_FULL) state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (done)
                    state_d = (in_cnt_q != '0 && out_cnt_d != OUT_FULL) ? ISSUE : IDLE;
                else
                    tmo_d = tmo_q + TCW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        f_din_valid = (state_q == ISSUE);
        busy        = (state_q != IDLE);
        f_din       = f_din_q;
        timeout_err = tmo_err_q;
        m_data      = m_valid ? out_mem_q[out_rd_q] : '0;
    end

    // state, timeout counter, held filter input, sticky error
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            tmo_q     <= '0;
            f_din_q   <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            // head is loaded as ISSUE is entered so f_din is valid with the pulse
            if (issue_go) f_din_q <= in_mem_q[in_rd_q];
            if (tmo_hit)  tmo_err_q <= 1'b1;
        end
    end

    // input FIFO pointers and count (head popped at the end of ISSUE)
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_wr_q  <= '0;
            in_rd_q  <= '0;
            in_cnt_q <= '0;
        end else begin
            if (in_push) in_wr_q <= in_wr_q + IAW'(1);
            if (in_pop)  in_rd_q <= in_rd_q + IAW'(1);
            in_cnt_q <= in_cnt_d;
        end
    end

    // output FIFO pointers and count
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_wr_q  <= '0;
            out_rd_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            if (out_wr)  out_wr_q <= out_wr_q + OAW'(1);
            if (out_pop) out_rd_q <= out_rd_q + OAW'(1);
            out_cnt_q <= out_cnt_d;
        end
    end

    // FIFO storage; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (in_push) in_mem_q[in_wr_q]   <= s_data;
        if (out_wr)  out_mem_q[out_wr_q] <= out_wdata;
    end

`ifdef IIR_FEEDER_STAT_EN
    logic [15:0] stat_samples_q;
    logic [7:0]  stat_timeouts_q;

    // saturating result / timeout counters, updated with the output FIFO write
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_samples_q  <= '0;
            stat_timeouts_q <= '0;
        end else begin
            if (out_wr && stat_samples_q != '1)   stat_samples_q  <= stat_samples_q + 16'd1;
            if (tmo_hit && stat_timeouts_q != '1) stat_timeouts_q <= stat_timeouts_q + 8'd1;
        end
    end

    assign stat_samples  = stat_samples_q;
    assign stat_timeouts = stat_timeouts_q;
`endif

endmodule

// File: tb/tb_iir_m_feeder.sv
// Directed bench for iir_m_feeder. A behavioural filter answers
// f_din ^ 18'h01800 six cycles after each issue pulse (when enabled).
module tb_iir_m_feeder;
    localparam int DW = 18;
    localparam logic [DW-1:0] MASK = 18'h01800;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] f_din;
    logic          f_din_valid;
    logic [DW-1:0] f_dout;
    logic          f_dout_valid;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          busy;
    logic          timeout_err;
`ifdef IIR_FEEDER_STAT_EN
    logic [15:0]   stat_samples;
    logic [7:0]    stat_timeouts;
`endif

    iir_m_feeder #(.DW(DW), .IN_DEPTH(4), .OUT_DEPTH(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .f_din(f_din), .f_din_valid(f_din_valid),
        .f_dout(f_dout), .f_dout_valid(f_dout_valid),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .timeout_err(timeout_err)
`ifdef IIR_FEEDER_STAT_EN
        , .stat_samples(stat_samples), .stat_timeouts(stat_timeouts)
`endif
    );

    always #5 clk = ~clk;

    // filter model: 6-cycle delay line, not reset so stale strobes survive a DUT reset
    logic          filt_en;
    logic [5:0]    dl_v = '0;
    logic [DW-1:0] dl_d [6];
    always @(posedge clk) begin
        dl_v[0] <= f_din_valid && filt_en;
        dl_d[0] <= f_din ^ MASK;
        for (int i = 1; i < 6; i++) begin
            dl_v[i] <= dl_v[i-1];
            dl_d[i] <= dl_d[i-1];
        end
    end
    assign f_dout_valid = dl_v[5];
    assign f_dout       = dl_v[5] ? dl_d[5] : '0;

    // cycle counter and observation queues
    int            cyc = 0;
    int            issue_cyc [$];
    logic [DW-1:0] outq [$];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst === 1'b1 && f_din_valid === 1'b1) issue_cyc.push_back(cyc);
        if (m_valid === 1'b1 && m_ready === 1'b1) outq.push_back(m_data);
    end

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        int n;
        n = 0;
        s_data  = d;
        s_valid = 1'b1;
        while (!s_ready && n < 50) begin
            step();
            n++;
        end
        chk("push_ready", {31'd0, s_ready}, 32'd1);
        step();
        s_valid = 1'b0;
    endtask

    task automatic wait_issue(input string tag, output int t);
        int n;
        n = 0;
        while (!f_din_valid && n < 40) begin
            step();
            n++;
        end
        chk(tag, {31'd0, f_din_valid}, 32'd1);
        t = cyc;
    endtask

    logic [DW-1:0] a_in  [5];
    logic [DW-1:0] a_exp [5];
    logic [DW-1:0] b_exp [6];
    int ib, ob, t;

    initial begin
        a_in[0] = 18'h00001; a_in[1] = 18'h1FFFF; a_in[2] = 18'h20000;
        a_in[3] = 18'h3FFFF; a_in[4] = 18'h12345;
        a_exp[0] = 18'h01801; a_exp[1] = 18'h1E7FF; a_exp[2] = 18'h21800;
        a_exp[3] = 18'h3E7FF; a_exp[4] = 18'h13B45;
        b_exp[0] = 18'h01900; b_exp[1] = 18'h01A00; b_exp[2] = 18'h01B00;
        b_exp[3] = 18'h01C00; b_exp[4] = 18'h01D00; b_exp[5] = 18'h01E00;

        // reset held 3 cycles with s_valid high
        rst = 1'b0; s_valid = 1'b1; s_data = 18'h00005; m_ready = 1'b1; filt_en = 1'b1;
        repeat (3) step();
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_f_din_valid", {31'd0, f_din_valid}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_m_data", {14'd0, m_data}, 32'd0);
        chk("rst_f_din", {14'd0, f_din}, 32'd0);
`ifdef IIR_FEEDER_STAT_EN
        chk("rst_stat_samples", {16'd0, stat_samples}, 32'd0);
`endif
        rst = 1'b1; s_valid = 1'b0;
        step();
        chk("post_rst_s_ready", {31'd0, s_ready}, 32'd1);

        // single sample: written at cycle 0, issue at 2, m_valid at 9
        ib = issue_cyc.size();
        s_data = 18'h01000; s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        chk("single_c1_valid", {31'd0, f_din_valid}, 32'd0);
        step();
        chk("single_c2_valid", {31'd0, f_din_valid}, 32'd1);
        chk("single_c2_f_din", {14'd0, f_din}, 32'h01000);
        step();
        chk("single_c3_valid", {31'd0, f_din_valid}, 32'd0);
        chk("single_c3_busy", {31'd0, busy}, 32'd1);
        chk("single_c3_f_din", {14'd0, f_din}, 32'h01000);
        repeat (5) step();
        chk("single_c8_m_valid", {31'd0, m_valid}, 32'd0);
        chk("single_c8_f_din", {14'd0, f_din}, 32'h01000);
        step();
        chk("single_c9_m_valid", {31'd0, m_valid}, 32'd1);
        chk("single_c9_m_data", {14'd0, m_data}, 32'h00800);
        chk("single_c9_busy", {31'd0, busy}, 32'd0);
        step();
        chk("single_c10_m_valid", {31'd0, m_valid}, 32'd0);
        chk("single_issues", issue_cyc.size() - ib, 32'd1);

        // burst of 5: one word is in flight, so the 5th write fills the FIFO
        ib = issue_cyc.size(); ob = outq.size();
        for (int k = 0; k < 5; k++) begin
            s_data = a_in[k]; s_valid = 1'b1;
            chk("burst_s_ready", {31'd0, s_ready}, 32'd1);
            step();
        end
        s_valid = 1'b0;
        chk("burst_full_s_ready", {31'd0, s_ready}, 32'd0);
        repeat (40) step();
        chk("burst_issues", issue_cyc.size() - ib, 32'd5);
        for (int k = 1; k < 5; k++)
            chk("burst_spacing", issue_cyc[ib+k] - issue_cyc[ib+k-1], 32'd7);
        chk("burst_outs", outq.size() - ob, 32'd5);
        for (int k = 0; k < 5; k++)
            chk("burst_data", {14'd0, outq[ob+k]}, {14'd0, a_exp[k]});

        // back-pressure: 6 samples, only OUT_DEPTH issue while m_ready is low
        m_ready = 1'b0;
        ib = issue_cyc.size(); ob = outq.size();
        for (int k = 1; k <= 6; k++) push(DW'(k * 256));
        repeat (50) step();
        chk("bp_issues", issue_cyc.size() - ib, 32'd4);
        chk("bp_busy", {31'd0, busy}, 32'd0);
        chk("bp_m_valid", {31'd0, m_valid}, 32'd1);
        chk("bp_m_data", {14'd0, m_data}, 32'h01900);
        m_ready = 1'b1;
        repeat (40) step();
        chk("bp_issues_total", issue_cyc.size() - ib, 32'd6);
        chk("bp_outs", outq.size() - ob, 32'd6);
        for (int k = 0; k < 6; k++)
            chk("bp_data", {14'd0, outq[ob+k]}, {14'd0, b_exp[k]});

        // timeout: filter silent, abort after 15 WAIT cycles with a zero result
        filt_en = 1'b0; m_ready = 1'b0;
        ob = outq.size();
        push(18'h2AAAA);
        wait_issue("tmo_issue", t);
        repeat (15) step();
        chk("tmo_before_err", {31'd0, timeout_err}, 32'd0);
        chk("tmo_before_busy", {31'd0, busy}, 32'd1);
        step();
        chk("tmo_err", {31'd0, timeout_err}, 32'd1);
        chk("tmo_m_valid", {31'd0, m_valid}, 32'd1);
        chk("tmo_m_data", {14'd0, m_data}, 32'd0);
        chk("tmo_busy", {31'd0, busy}, 32'd0);
        filt_en = 1'b1; m_ready = 1'b1;
        step();
        push(18'h3FFFF);
        repeat (15) step();
        chk("tmo_outs", outq.size() - ob, 32'd2);
        chk("tmo_zero", {14'd0, outq[ob]}, 32'd0);
        chk("tmo_next_data", {14'd0, outq[ob+1]}, 32'h3E7FF);
        chk("tmo_err_sticky", {31'd0, timeout_err}, 32'd1);
`ifdef IIR_FEEDER_STAT_EN
        chk("stat_samples", {16'd0, stat_samples}, 32'd14);
        chk("stat_timeouts", {24'd0, stat_timeouts}, 32'd1);
`endif

        // reset while in WAIT; the stale strobe afterwards is ignored
        ob = outq.size();
        push(18'h05555);
        wait_issue("mid_issue", t);
        step(); step();
        chk("mid_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_err", {31'd0, timeout_err}, 32'd0);
        repeat (8) step();
        chk("mid_m_valid", {31'd0, m_valid}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_outs", outq.size() - ob, 32'd0);
`ifdef IIR_FEEDER_STAT_EN
        chk("mid_stat_samples", {16'd0, stat_samples}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
